// File: rtl/ahb_decoder.sv
// AHB-Lite address decoder with data-phase mux select and a built-in default slave
// that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR response.
module ahb_decoder #(
    parameter logic [31:0] S1_BASE     = 32'h0000_0000,
    parameter logic [31:0] S2_BASE     = 32'h1000_0000,
    parameter logic [31:0] S3_BASE     = 32'h2000_0000,
    parameter logic [31:0] S4_BASE     = 32'h3000_0000,
    parameter logic [31:0] REGION_MASK = 32'hF000_0000,
    parameter int          CNT_W       = 8
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic [31:0]      haddr,
    input  logic [1:0]       htrans,
    input  logic             hready,
    output logic             hsel_1,
    output logic             hsel_2,
    output logic             hsel_3,
    output logic             hsel_4,
    output logic [1:0]       sel,
    output logic             dflt_active,
    output logic             dflt_hreadyout,
    output logic             dflt_hresp,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] match;
    logic [1:0] idx;
    logic       any_match;
    logic       err_req;

    assign match[0] = ((haddr & REGION_MASK) == (S1_BASE & REGION_MASK));
    assign match[1] = ((haddr & REGION_MASK) == (S2_BASE & REGION_MASK));
    assign match[2] = ((haddr & REGION_MASK) == (S3_BASE & REGION_MASK));
    assign match[3] = ((haddr & REGION_MASK) == (S4_BASE & REGION_MASK));

    // Priority chain keeps the selects one-hot even if regions overlap.
    always_comb begin
        hsel_1    = 1'b0;
        hsel_2    = 1'b0;
        hsel_3    = 1'b0;
        hsel_4    = 1'b0;
        idx       = 2'b00;
        any_match = 1'b1;
        if (match[0]) begin
            hsel_1 = 1'b1;
            idx    = 2'b00;
        end else if (match[1]) begin
            hsel_2 = 1'b1;
            idx    = 2'b01;
        end else if (match[2]) begin
            hsel_3 = 1'b1;
            idx    = 2'b10;
        end else if (match[3]) begin
            hsel_4 = 1'b1;
            idx    = 2'b11;
        end else begin
            any_match = 1'b0;
        end
    end

    assign err_req = hready & htrans[1] & ~any_match;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            sel         <= 2'b00;
            dflt_active <= 1'b0;
        end else if (hready) begin
            sel         <= idx;
            dflt_active <= ~any_match;
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response outputs depend only on the registered state, never on haddr.
    always_comb begin
        state_nxt      = state;
        dflt_hreadyout = 1'b1;
        dflt_hresp     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (err_req) state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                dflt_hreadyout = 1'b0;
                dflt_hresp     = 1'b1;
                state_nxt      = ST_ERR2;
            end
            ST_ERR2: begin
                dflt_hresp = 1'b1;
                state_nxt  = err_req ? ST_ERR1 : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            err_cnt <= '0;
        end else if ((state == ST_ERR1) && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_ahb_decoder.sv
// Directed bench for ahb_decoder: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ahb_decoder;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        clk;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic        hsel_1, hsel_2, hsel_3, hsel_4;
    logic [1:0]  sel;
    logic        dflt_active, dflt_hreadyout, dflt_hresp;
    logic [7:0]  err_cnt;
    logic [1:0]  dbg_state;

    // Expected vector layout: {hsel_4..hsel_1, sel, dflt_active, hreadyout, hresp, err_cnt}
    logic [16:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;

    ahb_decoder dut (
        .hclk           (clk),
        .hresetn        (hresetn),
        .haddr          (haddr),
        .htrans         (htrans),
        .hready         (hready),
        .hsel_1         (hsel_1),
        .hsel_2         (hsel_2),
        .hsel_3         (hsel_3),
        .hsel_4         (hsel_4),
        .sel            (sel),
        .dflt_active    (dflt_active),
        .dflt_hreadyout (dflt_hreadyout),
        .dflt_hresp     (dflt_hresp),
        .err_cnt        (err_cnt),
        .dbg_state      (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic [3:0] hs, input logic [1:0] s,
                                       input logic da, input logic ro, input logic rs,
                                       input logic [7:0] c);
        return {hs, s, da, ro, rs, c};
    endfunction

    // Driver: inputs change 1 time unit after the rising edge; the expectation
    // covers the comb selects for these inputs and the registers loaded at that edge.
    task automatic step(input logic rstn, input logic [31:0] a, input logic [1:0] t,
                        input logic r, input logic chk, input logic [16:0] e,
                        input string nm);
        @(posedge clk);
        #1;
        hresetn = rstn;
        haddr   = a;
        htrans  = t;
        hready  = r;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [16:0] act;
        logic [16:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {hsel_4, hsel_3, hsel_2, hsel_1, sel, dflt_active,
                   dflt_hreadyout, dflt_hresp, err_cnt};
            checks = checks + 1;
            if (act !== e) begin
                failures = failures + 1;
                $display("FAIL %s: got hsel=%b sel=%b da=%b ro=%b rs=%b cnt=%0d, expected hsel=%b sel=%b da=%b ro=%b rs=%b cnt=%0d",
                         nm, act[16:13], act[12:11], act[10], act[9], act[8], act[7:0],
                         e[16:13], e[12:11], e[10], e[9], e[8], e[7:0]);
            end
        end
    end

    initial begin
        hresetn = 1'b0;
        haddr   = 32'h0;
        htrans  = T_IDLE;
        hready  = 1'b1;

        // Reset and decode sweep
        step(0, 32'h0000_0000, T_IDLE,   1, 1, mk(4'b0001, 2'b00, 0, 1, 0, 0), "reset");
        step(1, 32'h1000_0040, T_NONSEQ, 1, 1, mk(4'b0010, 2'b00, 0, 1, 0, 0), "hsel2_comb");
        step(1, 32'h0000_0000, T_NONSEQ, 1, 1, mk(4'b0001, 2'b01, 0, 1, 0, 0), "sel_01");
        step(1, 32'h2000_0000, T_NONSEQ, 1, 1, mk(4'b0100, 2'b00, 0, 1, 0, 0), "sel_00");
        step(1, 32'h3000_0010, T_SEQ,    1, 1, mk(4'b1000, 2'b10, 0, 1, 0, 0), "sel_10");
        step(1, 32'h2000_0000, T_NONSEQ, 1, 1, mk(4'b0100, 2'b11, 0, 1, 0, 0), "sel_11");

        // Wait-state hold
        step(1, 32'h0000_0000, T_IDLE,   0, 1, mk(4'b0001, 2'b10, 0, 1, 0, 0), "accept_s3");
        step(1, 32'h0000_0000, T_IDLE,   0, 1, mk(4'b0001, 2'b10, 0, 1, 0, 0), "hold_1");
        step(1, 32'h0000_0000, T_IDLE,   0, 1, mk(4'b0001, 2'b10, 0, 1, 0, 0), "hold_2");

        // Unmapped NONSEQ: two-cycle ERROR
        step(1, 32'h8000_0000, T_NONSEQ, 1, 1, mk(4'b0000, 2'b10, 0, 1, 0, 0), "hold_3");
        step(1, 32'h0000_0000, T_IDLE,   0, 1, mk(4'b0001, 2'b00, 1, 0, 1, 0), "err1");
        step(1, 32'h0000_0000, T_IDLE,   1, 1, mk(4'b0001, 2'b00, 1, 1, 1, 1), "err2");
        step(1, 32'h8000_0000, T_IDLE,   1, 1, mk(4'b0000, 2'b00, 0, 1, 0, 1), "err_done");

        // Unmapped IDLE is zero-wait OKAY; then back-to-back unmapped NONSEQ
        step(1, 32'h8000_0000, T_NONSEQ, 1, 1, mk(4'b0000, 2'b00, 1, 1, 0, 1), "unmapped_idle");
        step(1, 32'h9000_0000, T_NONSEQ, 0, 1, mk(4'b0000, 2'b00, 1, 0, 1, 1), "b2b_err1a");
        step(1, 32'h9000_0000, T_NONSEQ, 1, 1, mk(4'b0000, 2'b00, 1, 1, 1, 2), "b2b_err2a");
        step(1, 32'h1000_0000, T_NONSEQ, 0, 1, mk(4'b0010, 2'b00, 1, 0, 1, 2), "b2b_err1b");
        step(1, 32'h1000_0000, T_NONSEQ, 1, 1, mk(4'b0010, 2'b00, 1, 1, 1, 3), "b2b_err2b");
        step(1, 32'h0000_0000, T_IDLE,   1, 1, mk(4'b0001, 2'b01, 0, 1, 0, 3), "err2_to_mapped");

        // Unmapped BUSY is OKAY
        step(1, 32'hF000_0000, T_BUSY,   1, 1, mk(4'b0000, 2'b00, 0, 1, 0, 3), "busy_issue");
        step(1, 32'h0000_0000, T_IDLE,   1, 1, mk(4'b0001, 2'b00, 1, 1, 0, 3), "busy_okay");

        // Reset during ERR1 wins over an accepted mapped transfer
        step(1, 32'h8000_0000, T_NONSEQ, 1, 1, mk(4'b0000, 2'b00, 0, 1, 0, 3), "pre_rst_err");
        step(0, 32'h2000_0000, T_NONSEQ, 1, 1, mk(4'b0100, 2'b00, 1, 0, 1, 3), "rst_in_err1");
        step(1, 32'h3000_0000, T_NONSEQ, 1, 1, mk(4'b1000, 2'b00, 0, 1, 0, 0), "after_rst");
        step(1, 32'h0000_0000, T_IDLE,   1, 1, mk(4'b0001, 2'b11, 0, 1, 0, 0), "post_rst_sel");

        // Saturation: 260 back-to-back errors
        for (int i = 0; i < 260; i++) begin
            step(1, 32'h8000_0000, T_NONSEQ, 1, 0, '0, "");
            step(1, 32'h8000_0000, T_NONSEQ, 0, 0, '0, "");
        end
        step(1, 32'h0000_0000, T_IDLE,   1, 1, mk(4'b0001, 2'b00, 1, 1, 1, 8'd255), "sat_err2");
        step(1, 32'h0000_0000, T_IDLE,   1, 1, mk(4'b0001, 2'b00, 0, 1, 0, 8'd255), "sat_hold");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
